// File: rtl/param_fifo.sv
// Synchronous FIFO with a parameterised width and depth (depth need not be a power of two).
// It has threshold flags, sticky overflow/underflow error bits, and either a fall-through or a registered read port.
module param_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 3,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter bit FWFT     = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_valid,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       r_ready,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           data_out,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] fill_count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_fill_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // Flags decode only the registered count, so no input ever reaches a flag combinationally.
  assign fifo_full    = (r_fill_count == FULL_CNT);
  assign fifo_empty   = (r_fill_count == '0);
  assign almost_full  = (int'(r_fill_count) >= AF_LEVEL);
  assign almost_empty = (int'(r_fill_count) <= AE_LEVEL);
  assign fill_count   = r_fill_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // A request is accepted only when the registered state allows it.
  // At full, only the read goes through. At empty, only the write goes through.
  assign w_wr_acc = w_valid && !fifo_full;
  assign w_rd_acc = r_ready && !fifo_empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill_count <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      if (w_rd_acc) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_fill_count <= r_fill_count + CW'(1);
        2'b01:   r_fill_count <= r_fill_count - CW'(1);
        default: r_fill_count <= r_fill_count;
      endcase
      // A set event on the same edge wins over clr_err.
      r_overflow  <= (w_valid && fifo_full)  || (r_overflow  && !clr_err);
      r_underflow <= (r_ready && fifo_empty) || (r_underflow && !clr_err);
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = r_mem[r_rd_ptr];
    end else begin : g_registered
      logic [WIDTH-1:0] r_data_out;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_data_out <= '0;
        else if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
      end
      assign data_out = r_data_out;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: depth-3 fall-through and registered instances share one stimulus, and a depth-5 instance checks pointer wrap.
// A negedge monitor checks read data against the queues of expected words.
module tb_param_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        w_valid = 1'b0, r_ready = 1'b0, clr_err = 1'b0;
  logic [31:0] data_in = '0;
  logic        w5 = 1'b0, r5 = 1'b0, clr5 = 1'b0;
  logic [31:0] d5 = '0;

  logic [31:0] u3_dout, ur_dout, u5_dout;
  logic        u3_full, u3_empty, u3_af, u3_ae, u3_ovf, u3_unf;
  logic        ur_full, ur_empty, ur_af, ur_ae, ur_ovf, ur_unf;
  logic        u5_full, u5_empty, u5_af, u5_ae, u5_ovf, u5_unf;
  logic [1:0]  u3_fill, ur_fill;
  logic [2:0]  u5_fill;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] exp3[$];
  logic [31:0] expr[$];
  logic [31:0] exp5[$];

  always #5 clk = ~clk;

  param_fifo #(.WIDTH(32), .DEPTH(3), .FWFT(1'b1)) u3 (
    .clk(clk), .reset(reset), .w_valid(w_valid), .data_in(data_in), .r_ready(r_ready),
    .clr_err(clr_err), .data_out(u3_dout), .fifo_full(u3_full), .fifo_empty(u3_empty),
    .almost_full(u3_af), .almost_empty(u3_ae), .fill_count(u3_fill),
    .overflow(u3_ovf), .underflow(u3_unf));

  param_fifo #(.WIDTH(32), .DEPTH(3), .FWFT(1'b0)) ur (
    .clk(clk), .reset(reset), .w_valid(w_valid), .data_in(data_in), .r_ready(r_ready),
    .clr_err(clr_err), .data_out(ur_dout), .fifo_full(ur_full), .fifo_empty(ur_empty),
    .almost_full(ur_af), .almost_empty(ur_ae), .fill_count(ur_fill),
    .overflow(ur_ovf), .underflow(ur_unf));

  param_fifo #(.WIDTH(32), .DEPTH(5), .FWFT(1'b1)) u5 (
    .clk(clk), .reset(reset), .w_valid(w5), .data_in(d5), .r_ready(r5),
    .clr_err(clr5), .data_out(u5_dout), .fifo_full(u5_full), .fifo_empty(u5_empty),
    .almost_full(u5_af), .almost_empty(u5_ae), .fill_count(u5_fill),
    .overflow(u5_ovf), .underflow(u5_unf));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: read accepted with no expected word queued (t=%0t)", name, $time);
  endtask

  task automatic push3(input logic [31:0] v);
    exp3.push_back(v);
    expr.push_back(v);
  endtask

  // Drives one clock's worth of inputs, waits until just past the edge, then returns the inputs to idle.
  task automatic cyc(input logic wv, input logic [31:0] d, input logic rr, input logic clr = 1'b0);
    w_valid = wv; data_in = d; r_ready = rr; clr_err = clr;
    @(posedge clk); #1;
    w_valid = 1'b0; r_ready = 1'b0; clr_err = 1'b0;
  endtask

  task automatic cyc5(input logic wv, input logic [31:0] d, input logic rr);
    w5 = wv; d5 = d; r5 = rr;
    @(posedge clk); #1;
    w5 = 1'b0; r5 = 1'b0;
  endtask

  // Monitor: the fall-through instances present their data before the accepting edge.
  // The registered instance presents it on the negedge after that edge.
  logic        pend_r = 1'b0;
  logic [31:0] pend_val = '0;
  always @(negedge clk) begin
    if (pend_r) begin
      check("ur_read_data", ur_dout, pend_val);
      pend_r = 1'b0;
    end
    if (reset) begin
      if (r_ready && !u3_empty) begin
        if (exp3.size() == 0) unexpected("u3_read");
        else check("u3_read_data", u3_dout, exp3.pop_front());
      end
      if (r_ready && !ur_empty) begin
        if (expr.size() == 0) unexpected("ur_read");
        else begin
          pend_val = expr.pop_front();
          pend_r   = 1'b1;
        end
      end
      if (r5 && !u5_empty) begin
        if (exp5.size() == 0) unexpected("u5_read");
        else check("u5_read_data", u5_dout, exp5.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while reset is held low.
    #2;
    check("rst_fill", 32'(u3_fill), 32'd0);
    check("rst_empty", 32'(u3_empty), 32'd1);
    check("rst_full", 32'(u3_full), 32'd0);
    check("rst_ae", 32'(u3_ae), 32'd1);
    check("rst_af", 32'(u3_af), 32'd0);
    check("rst_ovf_unf", 32'({u3_ovf, u3_unf}), 32'd0);
    check("rst_ur_dout", ur_dout, 32'd0);
    #10 reset = 1'b1;

    // A read while empty sets underflow and leaves the count at 0.
    cyc(1'b0, 32'd0, 1'b1);
    check("unf_set", 32'(u3_unf), 32'd1);
    check("unf_fill", 32'(u3_fill), 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    check("unf_clr", 32'(u3_unf), 32'd0);

    // Fill to DEPTH=3, watching the threshold flags (AF_LEVEL=2, AE_LEVEL=1).
    for (int i = 0; i < 3; i++) begin
      push3(32'(i));
      cyc(1'b1, 32'(i), 1'b0);
      check("fill_cnt", 32'(u3_fill), 32'(i + 1));
      check("fill_full", 32'(u3_full), 32'(i == 2));
      check("fill_af", 32'(u3_af), 32'(i >= 1));
      check("fill_ae", 32'(u3_ae), 32'(i == 0));
    end
    cyc(1'b1, 32'd3, 1'b0);
    check("ovf_set", 32'(u3_ovf), 32'd1);
    check("ovf_fill", 32'(u3_fill), 32'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1);
    check("drain_empty", 32'(u3_empty), 32'd1);
    check("drain_ur_empty", 32'(ur_empty), 32'd1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    check("ovf_clr", 32'(u3_ovf), 32'd0);

    // At full, a simultaneous read and write: only the read is accepted, and overflow sets.
    push3(32'h11); cyc(1'b1, 32'h11, 1'b0);
    push3(32'h22); cyc(1'b1, 32'h22, 1'b0);
    push3(32'h33); cyc(1'b1, 32'h33, 1'b0);
    cyc(1'b1, 32'h44, 1'b1);
    check("full_rw_fill", 32'(u3_fill), 32'd2);
    check("full_rw_ovf", 32'(u3_ovf), 32'd1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    check("full_rw_clr", 32'(u3_ovf), 32'd0);
    push3(32'h55); cyc(1'b1, 32'h55, 1'b0);
    check("refill_full", 32'(u3_full), 32'd1);
    cyc(1'b1, 32'h66, 1'b0, 1'b1);
    check("set_beats_clr", 32'(u3_ovf), 32'd1);
    check("set_beats_clr_fill", 32'(u3_fill), 32'd3);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    check("ovf_clr2", 32'(u3_ovf), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1);
    check("drain2_fill", 32'(ur_fill), 32'd0);

    // At empty, a simultaneous read and write: only the write is accepted, and underflow sets.
    push3(32'h77);
    cyc(1'b1, 32'h77, 1'b1);
    check("empty_rw_fill", 32'(u3_fill), 32'd1);
    check("empty_rw_unf", 32'(u3_unf), 32'd1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    check("empty_rw_clr", 32'(u3_unf), 32'd0);
    cyc(1'b0, 32'd0, 1'b1);
    check("ur_dout_77", ur_dout, 32'h77);

    // Read latency: the fall-through port shows the word at once, and the registered port only after the accepting edge.
    push3(32'hA5A5A5A5);
    cyc(1'b1, 32'hA5A5A5A5, 1'b0);
    check("fwft_zero_lat", u3_dout, 32'hA5A5A5A5);
    check("reg_holds", ur_dout, 32'h77);
    cyc(1'b0, 32'd0, 1'b1);
    check("reg_one_lat", ur_dout, 32'hA5A5A5A5);
    check("lat_fill", 32'(u3_fill), 32'd0);

    // Reset pulsed between edges, with two entries stored, takes effect at once.
    cyc(1'b1, 32'h1, 1'b0);
    cyc(1'b1, 32'h2, 1'b0);
    check("pre_rst_fill", 32'(u3_fill), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("async_rst_fill", 32'(u3_fill), 32'd0);
    check("async_rst_empty", 32'(u3_empty), 32'd1);
    check("async_rst_ur_dout", ur_dout, 32'd0);
    #2 reset = 1'b1;
    push3(32'h88);
    cyc(1'b1, 32'h88, 1'b0);
    cyc(1'b0, 32'd0, 1'b1);

    // DEPTH=5: 12 writes and 12 reads, interleaved so that both pointers wrap twice.
    for (int i = 0; i < 4; i++) begin
      exp5.push_back(32'h100 + 32'(i));
      cyc5(1'b1, 32'h100 + 32'(i), 1'b0);
    end
    check("d5_fill4", 32'(u5_fill), 32'd4);
    check("d5_af", 32'(u5_af), 32'd1);
    check("d5_not_full", 32'(u5_full), 32'd0);
    for (int i = 4; i < 12; i++) begin
      exp5.push_back(32'h100 + 32'(i));
      cyc5(1'b1, 32'h100 + 32'(i), 1'b1);
      check("d5_fill_steady", 32'(u5_fill), 32'd4);
    end
    for (int i = 0; i < 4; i++) cyc5(1'b0, 32'd0, 1'b1);
    check("d5_empty", 32'(u5_empty), 32'd1);
    check("d5_no_errs", 32'({u5_ovf, u5_unf}), 32'd0);

    cyc(1'b0, 32'd0, 1'b0);
    check("q3_drained", 32'(exp3.size()), 32'd0);
    check("qr_drained", 32'(expr.size()), 32'd0);
    check("q5_drained", 32'(exp5.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 3: number of entries, SHALL be >= 2, not restricted to powers of two.
REQ-003 Parameter AF_LEVEL, default DEPTH-1: almost_full asserts when fill_count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 1: almost_empty asserts when fill_count <= AE_LEVEL.
REQ-005 Parameter FWFT, default 1: 1 = first-word-fall-through read mode, 0 = registered read mode.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 w_valid  input  1  write request.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 r_ready  input  1  read request.
REQ-011 data_out  output  WIDTH  read data.
REQ-012 fifo_full  output  1  fill_count == DEPTH.
REQ-013 fifo_empty  output  1  fill_count == 0.
REQ-014 almost_full  output  1  threshold flag per REQ-003.
REQ-015 almost_empty  output  1  threshold flag per REQ-004.
REQ-016 fill_count  output  $clog2(DEPTH+1)  entries currently stored.
REQ-017 overflow  output  1  sticky: write attempted while full.
REQ-018 underflow  output  1  sticky: read attempted while empty.
REQ-019 clr_err  input  1  synchronous clear of overflow/underflow.

Function
REQ-020 Write SHALL be accepted on a rising edge iff w_valid=1 and fifo_full=0; data_in is stored at wr_ptr.
REQ-021 Read SHALL be accepted on a rising edge iff r_ready=1 and fifo_empty=0; rd_ptr advances.
REQ-022 wr_ptr/rd_ptr SHALL count 0..DEPTH-1 and wrap DEPTH-1 -> 0 on accept.
REQ-023 fill_count SHALL be +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write and read.
REQ-024 All flags SHALL be combinational decodes of the registered fill_count (registered state, no input-to-flag path).
REQ-025 At full, simultaneous w_valid and r_ready: read accepted, write rejected, overflow set, fill_count becomes DEPTH-1.
REQ-026 At empty, simultaneous w_valid and r_ready: write accepted, read rejected, underflow set, fill_count becomes 1.
REQ-027 FWFT=1: data_out SHALL equal the entry at rd_ptr whenever fifo_empty=0 (zero-cycle latency); value when empty is don't-care.
REQ-028 FWFT=0: data_out SHALL be a register loaded with the entry at rd_ptr on the edge a read is accepted (1-cycle latency), holding otherwise.
REQ-029 overflow SHALL set on any edge with w_valid=1 and fifo_full=1; underflow on any edge with r_ready=1 and fifo_empty=1.
REQ-030 clr_err=1 SHALL clear both sticky bits on the edge; a same-edge set event takes priority over clear.
REQ-031 Rejected requests SHALL not alter pointers, fill_count or memory.

Reset
REQ-032 reset=0 SHALL immediately clear wr_ptr, rd_ptr, fill_count, overflow, underflow and the FWFT=0 data_out register to 0.
REQ-033 After reset: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0.
REQ-034 Memory array contents SHALL not be reset; reset mid-transfer discards all stored entries.

Verification
REQ-035 After reset, no requests -> fifo_empty=1, fill_count=0, r_ready=1 for one cycle -> underflow=1, fill_count stays 0.
REQ-036 DEPTH=3: write 0,1,2 -> fifo_full=1 after third edge; write 3 -> rejected, overflow=1; read three -> 0,1,2 in order.
REQ-037 DEPTH=5: 12 writes interleaved with 12 reads -> pointers wrap twice, output order equals input order, fill_count never exceeds 5.
REQ-038 Full FIFO, w_valid=r_ready=1 one cycle -> fill_count DEPTH-1, overflow=1; then clr_err=1 -> overflow=0.
REQ-039 FWFT=0 vs FWFT=1, write 0xA5A5A5A5 then read -> data_out valid same cycle (FWFT=1) / one edge after accept (FWFT=0).
REQ-040 Two entries stored, reset pulsed low mid-cycle -> fill_count=0, fifo_empty=1 without waiting for clk.
